// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if
// Fetch port between the instruction fetch unit and the memory arbiter.
//   mem_rdy_in     arbiter -> fetch  arbiter accepts/serves the fetch port
//   mem_en_out     fetch -> arbiter  fetch request, level-held until response
//   mem_pc_out     fetch -> arbiter  byte address of the requested word
//   mem_inst_en_in arbiter -> fetch  one-cycle pulse, mem_inst_in valid
//   mem_inst_in    arbiter -> fetch  fetched 32-bit word
// The master modport is the fetch unit, the slave modport the arbiter side.
// ---------------------------------------------------------------------------
interface ifetch_unit_if;
    logic        mem_rdy_in;
    logic        mem_en_out;
    logic [31:0] mem_pc_out;
    logic        mem_inst_en_in;
    logic [31:0] mem_inst_in;

    modport master (
        input  mem_rdy_in,
        output mem_en_out,
        output mem_pc_out,
        input  mem_inst_en_in,
        input  mem_inst_in
    );

    modport slave (
        output mem_rdy_in,
        input  mem_en_out,
        input  mem_pc_out,
        output mem_inst_en_in,
        output mem_inst_in
    );
endinterface

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch with a direct-mapped, one-word-per-line instruction cache.
// A hit in IDLE delivers the cached word to the decoder on the next edge and
// advances the PC; a miss raises a memory request and waits in WAIT for the
// response, which fills the line; the instruction then leaves through the
// normal hit path on the following cycle.
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   rdy_in                   global enable; low freezes the unit
//   mem                      fetch port to the memory arbiter (master side)
//   iq_full_in               instruction queue cannot accept this cycle
//   inst_en_out/inst_out/pc_out  one-cycle delivery to the decoder
//   rob_flush_in/rob_target_pc_in  redirect request and target PC
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter int          ICACHE_INDEX_BITS = 4,
    parameter logic [31:0] RESET_PC          = 32'h0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    ifetch_unit_if.master        mem,
    input  logic                 iq_full_in,
    output logic                 inst_en_out,
    output logic [31:0]          inst_out,
    output logic [31:0]          pc_out,
    input  logic                 rob_flush_in,
    input  logic [31:0]          rob_target_pc_in
);
    localparam int LINES = 1 << ICACHE_INDEX_BITS;
    localparam int TAG_W = 30 - ICACHE_INDEX_BITS;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic        req_reg;
    logic [31:0] mem_pc_reg;
    logic        inst_en_reg;
    logic [31:0] inst_reg;
    logic [31:0] pc_out_reg;

    // Cache storage: tags and data need no reset, only the valid bits do.
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];
    logic [LINES-1:0] valid_vec;

    logic [ICACHE_INDEX_BITS-1:0] pc_idx;
    logic [TAG_W-1:0]             pc_tag;
    logic                         hit;
    logic                         fill_we;
    logic                         unused_mem_rdy;

    assign pc_idx = pc_reg[ICACHE_INDEX_BITS+1:2];
    assign pc_tag = pc_reg[31:ICACHE_INDEX_BITS+2];
    assign hit    = valid_vec[pc_idx] && (tag_mem[pc_idx] == pc_tag);

    // The request is always kept up until the response arrives, so the
    // arbiter's accept signal carries no information for this unit.
    assign unused_mem_rdy = mem.mem_rdy_in;

    // A response is only written when nothing with higher priority (reset,
    // stall, flush) claims the same edge. The PC is frozen while waiting, so
    // it still addresses the line being filled.
    assign fill_we = !rst_in && rdy_in && !rob_flush_in &&
                     (state_reg == ST_WAIT) && mem.mem_inst_en_in;

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : gen_line
            logic valid_reg;
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    valid_reg <= 1'b0;
                end else if (fill_we && (pc_idx == ICACHE_INDEX_BITS'(gi))) begin
                    valid_reg <= 1'b1;
                end
            end
            assign valid_vec[gi] = valid_reg;
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            tag_mem[pc_idx]  <= pc_tag;
            data_mem[pc_idx] <= mem.mem_inst_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= RESET_PC;
            req_reg     <= 1'b0;
            mem_pc_reg  <= 32'h0;
            inst_en_reg <= 1'b0;
            inst_reg    <= 32'h0;
            pc_out_reg  <= 32'h0;
        end else if (!rdy_in) begin
            // Frozen, but the delivery strobe must not repeat.
            inst_en_reg <= 1'b0;
        end else begin
            inst_en_reg <= 1'b0;
            if (rob_flush_in) begin
                // Redirect wins over any hit or response on the same edge.
                pc_reg    <= rob_target_pc_in;
                state_reg <= ST_IDLE;
                req_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (hit) begin
                            if (!iq_full_in) begin
                                inst_en_reg <= 1'b1;
                                inst_reg    <= data_mem[pc_idx];
                                pc_out_reg  <= pc_reg;
                                pc_reg      <= pc_reg + 32'd4;
                            end
                        end else begin
                            state_reg  <= ST_WAIT;
                            req_reg    <= 1'b1;
                            mem_pc_reg <= pc_reg;
                        end
                    end
                    ST_WAIT: begin
                        if (mem.mem_inst_en_in) begin
                            req_reg   <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Dropping the request combinationally in the response cycle keeps the
    // arbiter from granting the port a second time.
    assign mem.mem_en_out = req_reg & ~mem.mem_inst_en_in;
    assign mem.mem_pc_out = mem_pc_reg;
    assign inst_en_out    = inst_en_reg;
    assign inst_out       = inst_reg;
    assign pc_out         = pc_out_reg;
endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
// Directed scenarios (cold start, loop hits, backpressure, conflict miss,
// flush against response, PC wrap, stall, reset while waiting) followed by a
// randomized run against a transaction-level reference: expected delivery
// order from a PC counter, memory contents from a fixed function, and cache
// residency from a map of line -> cached address.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;
    localparam int IDX   = 4;
    localparam int LINES = 1 << IDX;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        iq_full;
    logic        inst_en;
    logic [31:0] inst;
    logic [31:0] pc_o;
    logic        flush;
    logic [31:0] tgt;

    int checks = 0;
    int errors = 0;

    ifetch_unit_if mem_bus ();

    ifetch_unit #(
        .ICACHE_INDEX_BITS (IDX),
        .RESET_PC          (32'h0)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .rdy_in           (rdy),
        .mem              (mem_bus),
        .iq_full_in       (iq_full),
        .inst_en_out      (inst_en),
        .inst_out         (inst),
        .pc_out           (pc_o),
        .rob_flush_in     (flush),
        .rob_target_pc_in (tgt)
    );

    always #5 clk = ~clk;

    // Backing memory contents: word 0 is the canonical NOP.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("check %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, check its address, answer after lat cycles.
    task automatic serve(input logic [31:0] exp_addr, input int lat);
        int n = 0;
        while (!mem_bus.mem_en_out && n < 20) begin
            cyc();
            n++;
        end
        chk1("req_seen", mem_bus.mem_en_out, 1'b1);
        chk("req_addr", mem_bus.mem_pc_out, exp_addr);
        repeat (lat) cyc();
        mem_bus.mem_inst_in    = mem_word(mem_bus.mem_pc_out);
        mem_bus.mem_inst_en_in = 1'b1;
        #1;
        chk1("req_drop", mem_bus.mem_en_out, 1'b0);
        cyc();
        mem_bus.mem_inst_en_in = 1'b0;
        $display("serve addr=%h lat=%0d", exp_addr, lat);
    endtask

    task automatic expect_inst(input string tag, input logic [31:0] a);
        chk1({tag, "_en"}, inst_en, 1'b1);
        chk({tag, "_pc"}, pc_o, a);
        chk({tag, "_inst"}, inst, mem_word(a));
        $display("deliver %s pc=%h inst=%h", tag, pc_o, inst);
    endtask

    // Reference model state for the random phase.
    logic [31:0] cache_m [int];
    logic [31:0] m_pc;
    logic [31:0] req_addr;
    bit          waiting;
    int          lat;
    int          deliveries;
    logic        rdy_d, flush_d, memen_d, iqf_d;
    logic [31:0] tgt_d;

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % LINES);
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
        if (!cache_m.exists(line_of(a))) return 1'b0;
        return (cache_m[line_of(a)] == a);
    endfunction

    initial begin
        rst = 1'b1; rdy = 1'b1; iq_full = 1'b0; flush = 1'b0; tgt = 32'h0;
        mem_bus.mem_rdy_in     = 1'b1;
        mem_bus.mem_inst_en_in = 1'b0;
        mem_bus.mem_inst_in    = 32'h0;
        cyc(); cyc();
        chk1("rst_inst_en", inst_en, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc_out", pc_o, 32'h0);
        chk1("rst_mem_en", mem_bus.mem_en_out, 1'b0);
        chk("rst_mem_pc", mem_bus.mem_pc_out, 32'h0);
        rst = 1'b0;

        // Cold start: miss at 0, answer after five cycles.
        cyc();
        chk1("cold_req", mem_bus.mem_en_out, 1'b1);
        chk("cold_req_pc", mem_bus.mem_pc_out, 32'h0);
        chk1("cold_no_inst", inst_en, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk1("cold_hold", mem_bus.mem_en_out, 1'b1);
        end
        mem_bus.mem_inst_in    = mem_word(32'h0);
        mem_bus.mem_inst_en_in = 1'b1;
        #1;
        chk1("cold_drop", mem_bus.mem_en_out, 1'b0);
        cyc();
        mem_bus.mem_inst_en_in = 1'b0;
        chk1("cold_fill_no_inst", inst_en, 1'b0);
        cyc();
        expect_inst("cold", 32'h0);
        chk("cold_nop", inst, 32'h0000_0013);
        cyc();
        chk1("cold_pulse_end", inst_en, 1'b0);
        chk1("cold_next_req", mem_bus.mem_en_out, 1'b1);
        chk("cold_next_pc", mem_bus.mem_pc_out, 32'h4);

        // Fill 0x4..0xC, then flush to 0 and run from the cache.
        for (int a = 4; a <= 12; a += 4) begin
            serve(32'(a), 2);
            cyc();
            expect_inst("fill", 32'(a));
        end
        flush = 1'b1; tgt = 32'h0;
        cyc();
        flush = 1'b0;
        chk1("flush_no_inst", inst_en, 1'b0);
        chk1("flush_req_clr", mem_bus.mem_en_out, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            expect_inst("loop", 32'(4 * i));
            chk1("loop_no_req", mem_bus.mem_en_out, 1'b0);
        end

        // Backpressure on a cached hit at 0x4.
        flush = 1'b1; tgt = 32'h4;
        cyc();
        flush = 1'b0; iq_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk1("bp_no_inst", inst_en, 1'b0);
            chk1("bp_no_req", mem_bus.mem_en_out, 1'b0);
        end
        iq_full = 1'b0;
        cyc();
        expect_inst("bp_release", 32'h4);

        // Conflict miss: 0x40 evicts 0x00 from line 0.
        flush = 1'b1; tgt = 32'h40;
        cyc();
        flush = 1'b0;
        serve(32'h40, 1);
        cyc();
        expect_inst("conflict", 32'h40);
        flush = 1'b1; tgt = 32'h0;
        cyc();
        flush = 1'b0;
        serve(32'h0, 1);
        cyc();
        expect_inst("refetch", 32'h0);

        // Flush coinciding with a memory response.
        flush = 1'b1; tgt = 32'h80;
        cyc();
        flush = 1'b0;
        cyc();
        chk1("fvr_req", mem_bus.mem_en_out, 1'b1);
        chk("fvr_req_pc", mem_bus.mem_pc_out, 32'h80);
        mem_bus.mem_inst_in    = mem_word(32'h80);
        mem_bus.mem_inst_en_in = 1'b1;
        flush = 1'b1; tgt = 32'h100;
        cyc();
        mem_bus.mem_inst_en_in = 1'b0;
        flush = 1'b0;
        #1;
        chk1("fvr_no_inst", inst_en, 1'b0);
        chk1("fvr_req_clr", mem_bus.mem_en_out, 1'b0);
        cyc();
        chk1("fvr_new_req", mem_bus.mem_en_out, 1'b1);
        chk("fvr_new_pc", mem_bus.mem_pc_out, 32'h100);
        flush = 1'b1; tgt = 32'h0;
        cyc();
        flush = 1'b0;
        cyc();
        expect_inst("fvr_line_kept", 32'h0);

        // PC wrap at the top of the address space.
        flush = 1'b1; tgt = 32'hFFFF_FFFC;
        cyc();
        flush = 1'b0;
        serve(32'hFFFF_FFFC, 1);
        cyc();
        expect_inst("wrap_top", 32'hFFFF_FFFC);
        cyc();
        expect_inst("wrap_zero", 32'h0);

        // Stall: rdy low freezes everything, including a flush.
        rdy = 1'b0; flush = 1'b1; tgt = 32'h300;
        cyc();
        flush = 1'b0;
        chk1("stall_no_inst", inst_en, 1'b0);
        cyc();
        chk1("stall_no_inst2", inst_en, 1'b0);
        rdy = 1'b1;
        cyc();
        expect_inst("stall_release", 32'h4);

        // Reset while a miss is outstanding; response in the same cycle.
        flush = 1'b1; tgt = 32'h200;
        cyc();
        flush = 1'b0;
        cyc();
        chk1("rw_req", mem_bus.mem_en_out, 1'b1);
        rst = 1'b1;
        mem_bus.mem_inst_in    = mem_word(32'h200);
        mem_bus.mem_inst_en_in = 1'b1;
        cyc();
        rst = 1'b0;
        mem_bus.mem_inst_en_in = 1'b0;
        #1;
        chk1("rw_req_drop", mem_bus.mem_en_out, 1'b0);
        chk1("rw_inst_en", inst_en, 1'b0);
        chk("rw_pc_out", pc_o, 32'h0);
        chk("rw_inst", inst, 32'h0);
        chk("rw_mem_pc", mem_bus.mem_pc_out, 32'h0);
        cyc();
        chk1("rw_cold_req", mem_bus.mem_en_out, 1'b1);
        chk("rw_cold_pc", mem_bus.mem_pc_out, 32'h0);

        // Randomized run against the reference model.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_pc = 32'h0; waiting = 1'b0; lat = 0; deliveries = 0;
        rdy_d = 1'b1; flush_d = 1'b0; memen_d = 1'b0; iqf_d = 1'b0; tgt_d = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (rdy_d && flush_d) begin
                chk1("rnd_flush_no_inst", inst_en, 1'b0);
                m_pc    = tgt_d;
                waiting = 1'b0;
            end else begin
                if (!rdy_d || iqf_d) chk1("rnd_stall_no_inst", inst_en, 1'b0);
                if (inst_en) begin
                    chk("rnd_pc", pc_o, m_pc);
                    chk("rnd_inst", inst, mem_word(m_pc));
                    $display("rnd deliver pc=%h inst=%h", pc_o, inst);
                    m_pc = m_pc + 32'd4;
                    deliveries++;
                end
                if (rdy_d && memen_d && waiting) begin
                    cache_m[line_of(req_addr)] = req_addr;
                    waiting = 1'b0;
                end
            end
            mem_bus.mem_inst_en_in = 1'b0;
            #1;
            if (mem_bus.mem_en_out) begin
                if (!waiting) begin
                    chk("rnd_req_pc", mem_bus.mem_pc_out, m_pc);
                    chk1("rnd_req_is_miss", model_hit(m_pc), 1'b0);
                    waiting  = 1'b1;
                    req_addr = mem_bus.mem_pc_out;
                    lat      = $urandom_range(0, 4);
                end else begin
                    chk("rnd_req_stable", mem_bus.mem_pc_out, req_addr);
                end
            end else if (waiting) begin
                chk1("rnd_req_held", mem_bus.mem_en_out, 1'b1);
            end
            rdy     = ($urandom_range(0, 9) != 0);
            iq_full = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0)
                tgt = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
            else
                tgt = 32'($urandom_range(0, 47)) << 2;
            if (waiting && mem_bus.mem_en_out) begin
                if (lat == 0) begin
                    mem_bus.mem_inst_in    = mem_word(req_addr);
                    mem_bus.mem_inst_en_in = 1'b1;
                    lat = $urandom_range(0, 4);
                end else begin
                    lat--;
                end
            end
            rdy_d   = rdy;
            flush_d = flush;
            memen_d = mem_bus.mem_inst_en_in;
            iqf_d   = iq_full;
            tgt_d   = tgt;
        end
        chk1("rnd_progress", deliveries > 50, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
